// File: rtl/tile_ram.sv
// tile_ram: ROWS x COLS tile memory with one write port, one registered read
// port and a background clear engine that fills a row, or the whole tile,
// with CLEAR_VALUE at one element per cycle.
// Optional feature: define TILE_RAM_BYPASS_EN for write-first read-during-write;
// otherwise same-address reads return the old contents (read-first).
module tile_ram #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ROWS        = 4,
    parameter int                    COLS        = 32,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [$clog2(ROWS)-1:0]   w_row,
    input  logic [$clog2(COLS)-1:0]   w_col,
    input  logic [DATA_WIDTH-1:0]     din,
    input  logic                      re,
    input  logic [$clog2(ROWS)-1:0]   r_row,
    input  logic [$clog2(COLS)-1:0]   r_col,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      dout_valid,
    input  logic                      clr_start,
    input  logic                      clr_all,
    input  logic [$clog2(ROWS)-1:0]   clr_row,
    output logic                      busy,
    output logic                      clr_done
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                state_q, state_d;
    logic                  all_q, all_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;

    logic [DATA_WIDTH-1:0] mem [ROWS][COLS];

    logic                  w_in_range;
    logic                  r_in_range;
    logic                  port_wr;
    logic                  clr_wr;
    logic                  wr_en;
    logic [RW-1:0]         wr_row;
    logic [CW-1:0]         wr_col;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  col_last;
    logic                  last_elem;

    // Select the single memory writer: clear engine while busy, else the port
    always_comb begin
        w_in_range = (int'(w_row) < ROWS) && (int'(w_col) < COLS);
        port_wr    = we && (state_q == IDLE) && w_in_range;
        clr_wr     = (state_q == CLEAR) && (int'(row_q) < ROWS);
        wr_en      = port_wr || clr_wr;
        wr_row     = (state_q == CLEAR) ? row_q : w_row;
        wr_col     = (state_q == CLEAR) ? col_q : w_col;
        wr_data    = (state_q == CLEAR) ? CLEAR_VALUE : din;
    end

    // Read mux; out-of-range addresses read as zero
    always_comb begin
        r_in_range = (int'(r_row) < ROWS) && (int'(r_col) < COLS);
        rd_data    = '0;
        if (r_in_range) begin
            rd_data = mem[r_row][r_col];
        end
`ifdef TILE_RAM_BYPASS_EN
        if (wr_en && (wr_row == r_row) && (wr_col == r_col)) begin
            rd_data = wr_data;
        end
`endif
    end

    // Next-state logic for the clear engine and the registered read port
    always_comb begin
        state_d   = state_q;
        all_d     = all_q;
        row_d     = row_q;
        col_d     = col_q;
        done_d    = 1'b0;
        dout_d    = re ? rd_data : dout_q;
        valid_d   = re;
        col_last  = (int'(col_q) == COLS - 1);
        last_elem = col_last && (!all_q || (int'(row_q) == ROWS - 1));
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    all_d   = clr_all;
                    row_d   = clr_all ? '0 : clr_row;
                    col_d   = '0;
                end
            end
            CLEAR: begin
                if (last_elem) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                end else if (col_last) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset aborts any clear in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            all_q   <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            all_q   <= all_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    // Storage array; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = (state_q == CLEAR);
    assign clr_done   = done_q;

endmodule

// File: tb/tb_tile_ram.sv
// Testbench for tile_ram: default 4x32 instance plus a 3-row instance with a
// non-zero clear value. Honours TILE_RAM_BYPASS_EN for read-during-write.
`timescale 1ns/1ps
module tb_tile_ram;

    localparam int ROWS = 4;
    localparam int COLS = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       we, re, clr_start, clr_all;
    logic [1:0] w_row, r_row, clr_row;
    logic [4:0] w_col, r_col;
    logic [7:0] din, dout;
    logic       dout_valid, busy, clr_done;

    logic       we3, re3, clr_start3, clr_all3;
    logic [1:0] w_row3, r_row3, clr_row3;
    logic [4:0] w_col3, r_col3;
    logic [7:0] din3, dout3;
    logic       valid3, busy3, done3;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] mdl [ROWS][COLS];
    bit         mdl_busy = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] last_dout = 8'h00;

    typedef struct packed {
        bit       we;
        bit [1:0] wr;
        bit [4:0] wc;
        bit [7:0] d;
        bit       re;
        bit [1:0] rr;
        bit [4:0] rc;
        bit [7:0] exp;
    } vec_t;
    vec_t vt[10];

    always #5 clk = ~clk;

    tile_ram #(.DATA_WIDTH(8), .ROWS(4), .COLS(32), .CLEAR_VALUE(8'h00)) u_dut (
        .clk(clk), .rst(rst), .we(we), .w_row(w_row), .w_col(w_col), .din(din),
        .re(re), .r_row(r_row), .r_col(r_col), .dout(dout), .dout_valid(dout_valid),
        .clr_start(clr_start), .clr_all(clr_all), .clr_row(clr_row),
        .busy(busy), .clr_done(clr_done)
    );

    tile_ram #(.DATA_WIDTH(8), .ROWS(3), .COLS(32), .CLEAR_VALUE(8'hE1)) u_dut3 (
        .clk(clk), .rst(rst), .we(we3), .w_row(w_row3), .w_col(w_col3), .din(din3),
        .re(re3), .r_row(r_row3), .r_col(r_col3), .dout(dout3), .dout_valid(valid3),
        .clr_start(clr_start3), .clr_all(clr_all3), .clr_row(clr_row3),
        .busy(busy3), .clr_done(done3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of the main instance: score the read issued this cycle
    task automatic tick(input bit use_tbl, input logic [7:0] tbl_exp);
        logic [7:0] e;
        bit         rd;
        rd = re;
        if (re) begin
            e = use_tbl ? tbl_exp : mdl[r_row][r_col];
`ifdef TILE_RAM_BYPASS_EN
            if (!use_tbl && we && !mdl_busy && w_row == r_row && w_col == r_col) e = din;
`endif
            exp_q.push_back(e);
        end
        if (we && !mdl_busy) mdl[w_row][w_col] = din;
        @(posedge clk);
        #1;
        if (rd) begin
            check("rd_valid", dout_valid, 1);
            e = exp_q.pop_front();
            check("rd_data", dout, e);
            last_dout = e;
        end else begin
            check("idle_valid", dout_valid, 0);
            check("hold_dout", dout, last_dout);
        end
    endtask

    task automatic t3();
        @(posedge clk);
        #1;
    endtask

    task automatic verify_rows(input bit [3:0] mask);
        for (int r = 0; r < ROWS; r++) begin
            if (mask[r]) begin
                for (int c = 0; c < COLS; c++) begin
                    re = 1'b1; r_row = 2'(r); r_col = 5'(c);
                    tick(1'b0, 8'h00);
                end
            end
        end
        re = 1'b0;
    endtask

    task automatic run_clear(input bit all, input logic [1:0] row, input int exp_cyc, input bit mid_we);
        int bcnt;
        int dcnt;
        bit prev_busy;
        clr_start = 1'b1; clr_all = all; clr_row = row;
        tick(1'b0, 8'h00);
        clr_start = 1'b0; clr_all = 1'b0; clr_row = 2'd0;
        mdl_busy  = 1'b1;
        bcnt = 0; dcnt = 0; prev_busy = 1'b1;
        for (int i = 0; i < exp_cyc + 6; i++) begin
            if (busy) bcnt++;
            if (clr_done) begin
                dcnt++;
                check("done_busy_edge", {prev_busy, busy}, 2'b10);
            end
            prev_busy = busy;
            re = (i == 5); r_row = 2'd3; r_col = 5'd0;
            we = mid_we && (i == 40); w_row = 2'd0; w_col = 5'd0; din = 8'h55;
            tick(1'b0, 8'h00);
        end
        re = 1'b0; we = 1'b0; mdl_busy = 1'b0;
        check("busy_cycles", bcnt, exp_cyc);
        check("done_pulses", dcnt, 1);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (all || r == int'(row)) mdl[r][c] = 8'h00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcnt;
        int dcnt;
        rst = 1'b1;
        we = 0; re = 0; clr_start = 0; clr_all = 0;
        w_row = 0; w_col = 0; din = 0; r_row = 0; r_col = 0; clr_row = 0;
        we3 = 0; re3 = 0; clr_start3 = 0; clr_all3 = 0;
        w_row3 = 0; w_col3 = 0; din3 = 0; r_row3 = 0; r_col3 = 0; clr_row3 = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", dout, 8'h00);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", clr_done, 0);
        rst = 1'b0;

        // Fill with a known pattern: value = r*40 + c + 1
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                we = 1'b1; w_row = 2'(r); w_col = 5'(c); din = 8'(r * 40 + c + 1);
                tick(1'b0, 8'h00);
            end
        we = 1'b0;

        // Vector table: {we, w_row, w_col, din, re, r_row, r_col, expected dout}
        vt[0] = '{1'b1, 2'd2, 5'd7,  8'hA5, 1'b0, 2'd0, 5'd0,  8'h00};
        vt[1] = '{1'b0, 2'd0, 5'd0,  8'h00, 1'b1, 2'd2, 5'd7,  8'hA5};
        vt[2] = '{1'b1, 2'd0, 5'd3,  8'h3C, 1'b1, 2'd1, 5'd5,  8'h2E};
        vt[3] = '{1'b0, 2'd0, 5'd0,  8'h00, 1'b1, 2'd0, 5'd3,  8'h3C};
        vt[4] = '{1'b0, 2'd0, 5'd0,  8'h00, 1'b1, 2'd3, 5'd31, 8'h98};
        vt[5] = '{1'b1, 2'd3, 5'd31, 8'h11, 1'b0, 2'd0, 5'd0,  8'h00};
`ifdef TILE_RAM_BYPASS_EN
        vt[6] = '{1'b1, 2'd3, 5'd31, 8'h3C, 1'b1, 2'd3, 5'd31, 8'h3C};
`else
        vt[6] = '{1'b1, 2'd3, 5'd31, 8'h3C, 1'b1, 2'd3, 5'd31, 8'h11};
`endif
        vt[7] = '{1'b0, 2'd0, 5'd0,  8'h00, 1'b1, 2'd3, 5'd31, 8'h3C};
        vt[8] = '{1'b0, 2'd0, 5'd0,  8'h00, 1'b0, 2'd0, 5'd0,  8'h00};
        vt[9] = '{1'b0, 2'd0, 5'd0,  8'h00, 1'b1, 2'd0, 5'd0,  8'h01};
        for (int i = 0; i < 10; i++) begin
            we = vt[i].we; w_row = vt[i].wr; w_col = vt[i].wc; din = vt[i].d;
            re = vt[i].re; r_row = vt[i].rr; r_col = vt[i].rc;
            tick(1'b1, vt[i].exp);
        end
        we = 1'b0; re = 1'b0;

        // Single-row clear of row 1 after filling it with the column index
        for (int c = 0; c < COLS; c++) begin
            we = 1'b1; w_row = 2'd1; w_col = 5'(c); din = 8'(c);
            tick(1'b0, 8'h00);
        end
        we = 1'b0;
        run_clear(1'b0, 2'd1, 32, 1'b0);
        verify_rows(4'b0011);

        // Whole-tile clear with a port write dropped mid-clear
        run_clear(1'b1, 2'd0, 128, 1'b1);
        verify_rows(4'b1111);

        // Reset aborting a row-2 clear after 10 elements
        for (int c = 0; c < COLS; c++) begin
            we = 1'b1; w_row = 2'd2; w_col = 5'(c); din = 8'(8'hC0 + c);
            tick(1'b0, 8'h00);
        end
        we = 1'b0;
        clr_start = 1'b1; clr_row = 2'd2;
        tick(1'b0, 8'h00);
        clr_start = 1'b0; clr_row = 2'd0;
        mdl_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            re = (i == 9); r_row = 2'd0; r_col = 5'd0;
            tick(1'b0, 8'h00);
        end
        re = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", dout_valid, 0);
        check("abort_dout", dout, 8'h00);
        check("abort_done", clr_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_dout = 8'h00;
        mdl_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("abort_no_done", clr_done, 0);
            check("abort_idle", busy, 0);
            tick(1'b0, 8'h00);
        end
        for (int c = 0; c < 10; c++) mdl[2][c] = 8'h00;
        verify_rows(4'b0100);

        // Three-row instance: out-of-range row accesses
        we3 = 1'b1; w_row3 = 2'd2; w_col3 = 5'd0; din3 = 8'h12; t3();
        w_row3 = 2'd3; din3 = 8'h77; t3();
        we3 = 1'b0;
        re3 = 1'b1; r_row3 = 2'd3; r_col3 = 5'd0; t3();
        check("oor_rd_data", dout3, 8'h00);
        check("oor_rd_valid", valid3, 1);
        r_row3 = 2'd2; t3();
        check("r3_rd_data", dout3, 8'h12);
        re3 = 1'b0; t3();
        check("r3_idle_valid", valid3, 0);
        check("r3_hold", dout3, 8'h12);

        // Out-of-range clear row: full duration, clr_start while busy ignored
        clr_start3 = 1'b1; clr_row3 = 2'd3; t3();
        clr_start3 = 1'b0;
        bcnt = 0; dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy3) bcnt++;
            if (done3) dcnt++;
            clr_start3 = (i == 5); clr_all3 = (i == 5);
            t3();
        end
        clr_start3 = 1'b0; clr_all3 = 1'b0;
        check("oor_clr_cycles", bcnt, 32);
        check("oor_clr_done", dcnt, 1);
        re3 = 1'b1; r_row3 = 2'd2; r_col3 = 5'd0; t3();
        check("oor_clr_nowrite", dout3, 8'h12);
        re3 = 1'b0;

        // Clear request together with a port write; clear value parameter
        clr_start3 = 1'b1; clr_row3 = 2'd2;
        we3 = 1'b1; w_row3 = 2'd0; w_col3 = 5'd4; din3 = 8'h5A; t3();
        clr_start3 = 1'b0; we3 = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy3) bcnt++;
            t3();
        end
        check("r3_clr_cycles", bcnt, 32);
        re3 = 1'b1; r_row3 = 2'd0; r_col3 = 5'd4; t3();
        check("same_cycle_wr", dout3, 8'h5A);
        r_row3 = 2'd2; r_col3 = 5'd0; t3();
        check("clr_val_c0", dout3, 8'hE1);
        r_col3 = 5'd31; t3();
        check("clr_val_c31", dout3, 8'hE1);
        re3 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
